gray_counter_sched: RTL and testbench

- Round-robin scheduler that shares one 3-bit Gray counter (enable, sticky overflow, sync reset) among NUM_REQ requesters.
- Each granted job either advances the counter by a requested number of steps or clears it.
- Returns the resulting Gray code, a per-job wrap flag and the counter's sticky overflow to the winning requester.
- Sits between requester logic and the counter instance; it is the only driver of the counter's En and Reset.

---
 rtl/gray_counter_sched.sv | 202 ++++++++++++++++++++
 tb/tb_gray_counter_sched.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/gray_counter_sched.sv
// Round-robin scheduler sharing one 3-bit Gray counter among NUM_REQ requesters.
// Ports: Clk/Reset (sync, active-high); Req/ReqClr/ReqSteps job requests;
//   Grant/Busy/Done/DoneId/DoneCode/DoneWrap/DoneOvf/Err job status;
//   CntEn/CntReset drive the counter, CntOutput/CntOverflow read it back.
// Build option: define GRAY_SCHED_CHECK_EN to build the Gray-step checker behind Err.
module gray_counter_sched #(
  parameter int NUM_REQ = 4,
  parameter int STEP_W  = 4
) (
  input  logic                      Clk,
  input  logic                      Reset,
  input  logic [NUM_REQ-1:0]        Req,
  input  logic [NUM_REQ-1:0]        ReqClr,
  input  logic [NUM_REQ*STEP_W-1:0] ReqSteps,
  output logic [NUM_REQ-1:0]        Grant,
  output logic                      Busy,
  output logic                      Done,
  output logic [2:0]                DoneId,
  output logic [2:0]                DoneCode,
  output logic                      DoneWrap,
  output logic                      DoneOvf,
  output logic                      Err,
  output logic                      CntEn,
  output logic                      CntReset,
  input  logic [2:0]                CntOutput,
  input  logic                      CntOverflow
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] RUN     = 2'd1;
  localparam logic [1:0] CAPTURE = 2'd2;
  localparam logic [1:0] DONE    = 2'd3;

  logic [1:0]         state_q, state_d;
  logic [2:0]         rr_q, rr_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic               clr_q, clr_d;
  logic [STEP_W-1:0]  rem_q, rem_d;
  logic [2:0]         id_q, id_d;
  logic               wrap_q, wrap_d;
  logic               done_q, done_d;
  logic [2:0]         done_id_q, done_id_d;
  logic [2:0]         done_code_q, done_code_d;
  logic               done_wrap_q, done_wrap_d;
  logic               done_ovf_q, done_ovf_d;

  // Arbiter: iterate from the farthest slot back to rr_q so the
  // last hit is the first asserted requester in ascending order.
  logic               found;
  int                 idx_c;
  logic [2:0]         win;
  logic [2:0]         win_nxt;
  logic [NUM_REQ-1:0] win_oh;
  logic               win_clr;
  logic [STEP_W-1:0]  win_steps;

  always_comb begin
    found     = 1'b0;
    idx_c     = 0;
    win       = '0;
    win_nxt   = '0;
    win_oh    = '0;
    win_clr   = 1'b0;
    win_steps = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx_c = (int'(rr_q) + k) % NUM_REQ;
      if (Req[idx_c]) begin
        found         = 1'b1;
        win           = 3'(idx_c);
        win_nxt       = 3'((idx_c + 1) % NUM_REQ);
        win_oh        = '0;
        win_oh[idx_c] = 1'b1;
        win_clr       = ReqClr[idx_c];
        win_steps     = ReqSteps[idx_c*STEP_W +: STEP_W];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    rr_d        = rr_q;
    grant_d     = grant_q;
    clr_d       = clr_q;
    rem_d       = rem_q;
    id_d        = id_q;
    wrap_d      = wrap_q;
    done_d      = 1'b0;
    done_id_d   = done_id_q;
    done_code_d = done_code_q;
    done_wrap_d = done_wrap_q;
    done_ovf_d  = done_ovf_q;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          grant_d = win_oh;
          clr_d   = win_clr;
          rem_d   = win_steps;
          id_d    = win;
          wrap_d  = 1'b0;
          rr_d    = win_nxt;
          state_d = (win_clr || win_steps != '0) ? RUN : CAPTURE;
        end
      end
      RUN: begin
        if (clr_q) begin
          state_d = CAPTURE;
        end else begin
          // Incrementing from the last code rolls the counter over.
          if (CntOutput == 3'b100) wrap_d = 1'b1;
          rem_d = rem_q - STEP_W'(1);
          if (rem_q == STEP_W'(1)) state_d = CAPTURE;
        end
      end
      CAPTURE: begin
        done_code_d = CntOutput;
        done_ovf_d  = CntOverflow;
        done_wrap_d = wrap_q;
        done_id_d   = id_q;
        grant_d     = '0;
        state_d     = DONE;
      end
      DONE: begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q     <= IDLE;
      rr_q        <= '0;
      grant_q     <= '0;
      clr_q       <= 1'b0;
      rem_q       <= '0;
      id_q        <= '0;
      wrap_q      <= 1'b0;
      done_q      <= 1'b0;
      done_id_q   <= '0;
      done_code_q <= '0;
      done_wrap_q <= 1'b0;
      done_ovf_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_q        <= rr_d;
      grant_q     <= grant_d;
      clr_q       <= clr_d;
      rem_q       <= rem_d;
      id_q        <= id_d;
      wrap_q      <= wrap_d;
      done_q      <= done_d;
      done_id_q   <= done_id_d;
      done_code_q <= done_code_d;
      done_wrap_q <= done_wrap_d;
      done_ovf_q  <= done_ovf_d;
    end
  end

  assign Grant    = grant_q;
  assign Busy     = (state_q != IDLE);
  assign Done     = done_q;
  assign DoneId   = done_id_q;
  assign DoneCode = done_code_q;
  assign DoneWrap = done_wrap_q;
  assign DoneOvf  = done_ovf_q;
  assign CntEn    = (state_q == RUN) && !clr_q;
  // Controller reset also clears the shared counter.
  assign CntReset = Reset || ((state_q == RUN) && clr_q);

`ifdef GRAY_SCHED_CHECK_EN
  logic [2:0] prev_q;
  logic       en_prev_q;
  logic       err_q, err_d;
  logic [2:0] diff;

  // A legal Gray increment flips exactly one bit.
  always_comb begin
    diff  = CntOutput ^ prev_q;
    err_d = err_q;
    if (en_prev_q && !(diff != 3'b0 && (diff & (diff - 3'b1)) == 3'b0))
      err_d = 1'b1;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      prev_q    <= '0;
      en_prev_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      prev_q    <= CntOutput;
      en_prev_q <= CntEn;
      err_q     <= err_d;
    end
  end

  assign Err = err_q;
`else
  assign Err = 1'b0;
`endif

endmodule

// File: tb/tb_gray_counter_sched.sv
// Bench for gray_counter_sched with a behavioural counter stand-in
// and a position/ownership reference model.
module tb_gray_counter_sched;
  localparam int N  = 4;
  localparam int SW = 4;

  logic              Clk = 1'b0;
  logic              Reset;
  logic [N-1:0]      Req, ReqClr;
  logic [N*SW-1:0]   ReqSteps;
  logic [N-1:0]      Grant;
  logic              Busy, Done, DoneWrap, DoneOvf, Err;
  logic [2:0]        DoneId, DoneCode;
  logic              CntEn, CntReset;
  logic [2:0]        CntOutput;
  logic              CntOverflow;

  int checks = 0;
  int errors = 0;

  always #5 Clk = ~Clk;

  gray_counter_sched #(.NUM_REQ(N), .STEP_W(SW)) dut (
    .Clk(Clk), .Reset(Reset), .Req(Req), .ReqClr(ReqClr),
    .ReqSteps(ReqSteps), .Grant(Grant), .Busy(Busy), .Done(Done),
    .DoneId(DoneId), .DoneCode(DoneCode), .DoneWrap(DoneWrap),
    .DoneOvf(DoneOvf), .Err(Err), .CntEn(CntEn), .CntReset(CntReset),
    .CntOutput(CntOutput), .CntOverflow(CntOverflow)
  );

  // Counter stand-in: binary count, Gray output, sticky overflow.
  logic [2:0] cnt_b;
  logic       ovf_r;
  always @(posedge Clk) begin
    if (CntReset) begin
      cnt_b <= 3'd0;
      ovf_r <= 1'b0;
    end else if (CntEn) begin
      cnt_b <= cnt_b + 3'd1;
      if (cnt_b == 3'd7) ovf_r <= 1'b1;
    end
  end
  assign CntOutput   = cnt_b ^ (cnt_b >> 1);
  assign CntOverflow = ovf_r;

  // Reference model state.
  int         m_pos;
  bit         m_ovf;
  int         m_rr;
  logic [2:0] gray_tab [8];

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pos = 0;
    m_ovf = 1'b0;
    m_rr  = 0;
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    @(posedge Clk); #1;
    Reset = 1'b0;
    model_reset();
  endtask

  task automatic run_job(input bit sticky);
    int w, st, t, en_n, rs_n, elat;
    bit clr, seen, ewrap;
    logic [2:0] ecode;
    w = -1;
    for (int k = 0; k < N; k++)
      if (w < 0 && Req[(m_rr + k) % N]) w = (m_rr + k) % N;
    if (w < 0) begin
      chk("no_request", 32'(Req), 32'hf);
      return;
    end
    clr  = ReqClr[w];
    st   = int'(ReqSteps[w*SW +: SW]);
    seen = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(posedge Clk); #1;
      if (c == 0) chk("done_pulse", 32'(Done), 32'd0);
      if (Grant != '0) seen = 1'b1;
    end
    chk("grant_seen", 32'(seen), 32'd1);
    if (!seen) return;
    chk("grant", 32'(Grant), 32'(1 << w));
    chk("busy", 32'(Busy), 32'd1);
    m_rr = (w + 1) % N;
    if (!sticky) begin
      Req[w] = 1'b0;
      ReqClr[w] = 1'($urandom);
      ReqSteps[w*SW +: SW] = SW'($urandom);
    end
    if (clr) begin
      m_pos = 0;
      m_ovf = 1'b0;
      ewrap = 1'b0;
      elat  = 3;
    end else begin
      ewrap = (m_pos + st) >= 8;
      m_pos = (m_pos + st) % 8;
      if (ewrap) m_ovf = 1'b1;
      elat  = st + 2;
    end
    ecode = gray_tab[m_pos];
    en_n = int'(CntEn);
    rs_n = int'(CntReset);
    t    = 0;
    seen = 1'b0;
    while (!seen && t < 40) begin
      @(posedge Clk); #1;
      t++;
      if (Done) seen = 1'b1;
      else begin
        en_n += int'(CntEn);
        rs_n += int'(CntReset);
      end
    end
    chk("done_latency", 32'(t), 32'(elat));
    chk("done_id", 32'(DoneId), 32'(w));
    chk("done_code", 32'(DoneCode), 32'(ecode));
    chk("done_wrap", 32'(DoneWrap), 32'(ewrap));
    chk("done_ovf", 32'(DoneOvf), 32'(m_ovf));
    chk("en_cycles", 32'(en_n), clr ? 32'd0 : 32'(st));
    chk("clr_cycles", 32'(rs_n), clr ? 32'd1 : 32'd0);
    chk("grant_drop", 32'(Grant), 32'd0);
    chk("err", 32'(Err), 32'd0);
  endtask

  initial begin
    int dn;
    bit gs;
    gray_tab = '{3'b000, 3'b001, 3'b011, 3'b010,
                 3'b110, 3'b111, 3'b101, 3'b100};
    Reset    = 1'b1;
    Req      = '0;
    ReqClr   = '0;
    ReqSteps = '0;
    @(posedge Clk); #1;
    @(posedge Clk); #1;
    chk("rst_grant", 32'(Grant), 32'd0);
    chk("rst_busy", 32'(Busy), 32'd0);
    chk("rst_done", 32'(Done), 32'd0);
    chk("rst_id", 32'(DoneId), 32'd0);
    chk("rst_code", 32'(DoneCode), 32'd0);
    chk("rst_wrap", 32'(DoneWrap), 32'd0);
    chk("rst_ovf", 32'(DoneOvf), 32'd0);
    chk("rst_err", 32'(Err), 32'd0);
    chk("rst_cnten", 32'(CntEn), 32'd0);
    chk("rst_cntreset", 32'(CntReset), 32'd1);
    Reset = 1'b0;
    model_reset();
    @(posedge Clk); #1;
    chk("idle_cntreset", 32'(CntReset), 32'd0);
    chk("idle_cnt", 32'(CntOutput), 32'd0);

    // Single requester, three steps from 000.
    ReqSteps[3:0] = 4'd3;
    Req = 4'b0001;
    run_job(1'b0);

    // All requesters held, one step each: order 0,1,2,3,0.
    do_reset();
    ReqClr   = '0;
    ReqSteps = 16'h1111;
    Req      = 4'b1111;
    repeat (5) run_job(1'b1);
    Req = '0;

    // Advance to position 4, then 5 steps through the wrap.
    do_reset();
    ReqClr = '0;
    ReqSteps = 16'h5040;
    Req = 4'b0010;
    run_job(1'b0);
    Req = 4'b1000;
    run_job(1'b0);

    // Clear job ignores its step count.
    ReqClr = 4'b0100;
    ReqSteps[11:8] = 4'd7;
    Req = 4'b0100;
    run_job(1'b0);

    // Zero-step job reports the prior code.
    ReqClr = '0;
    ReqSteps[7:4] = 4'd3;
    Req = 4'b0010;
    run_job(1'b0);
    ReqClr = '0;
    ReqSteps[3:0] = 4'd0;
    Req = 4'b0001;
    run_job(1'b0);

    // Reset on the second RUN cycle of a six-step job.
    ReqClr = '0;
    ReqSteps[15:12] = 4'd6;
    Req = 4'b1000;
    gs = 1'b0;
    for (int c = 0; c < 10 && !gs; c++) begin
      @(posedge Clk); #1;
      if (Grant != '0) gs = 1'b1;
    end
    chk("abort_grant_seen", 32'(gs), 32'd1);
    Req = '0;
    @(posedge Clk); #1;
    Reset = 1'b1;
    @(posedge Clk); #1;
    Reset = 1'b0;
    model_reset();
    chk("abort_grant", 32'(Grant), 32'd0);
    chk("abort_cnten", 32'(CntEn), 32'd0);
    chk("abort_cnt", 32'(CntOutput), 32'd0);
    chk("abort_busy", 32'(Busy), 32'd0);
    dn = 0;
    repeat (8) begin
      @(posedge Clk); #1;
      dn += int'(Done);
    end
    chk("abort_no_done", 32'(dn), 32'd0);
    ReqClr = '0;
    ReqSteps = 16'h1111;
    Req = 4'b1111;
    run_job(1'b0);
    Req = '0;

    // Randomised jobs, including max and zero step counts.
    for (int j = 0; j < 40; j++) begin
      for (int r = 0; r < N; r++) begin
        ReqClr[r] = ($urandom_range(0, 7) == 0);
        case ($urandom_range(0, 5))
          0:       ReqSteps[r*SW +: SW] = '1;
          1:       ReqSteps[r*SW +: SW] = '0;
          default: ReqSteps[r*SW +: SW] = SW'($urandom);
        endcase
      end
      Req = N'($urandom_range(1, (1 << N) - 1));
      run_job(1'b0);
      Req = '0;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
